sat_accum_pipe: RTL and testbench

Parametrised successor to the team's combinational saturating signed adder. Registered, valid-qualified block with two modes:
- Mode 0: saturating pairwise add of two signed samples.
- Mode 1: saturating accumulate of ACC_LEN samples into one frame result.
Output width is independent of input width. The block also reports per-result saturation flags and a sticky saturation event counter. It sits in DSP datapaths after the mixer/FIR stages, where the limited output word must never wrap.

---
 rtl/sat_accum_pipe.sv | 153 +++++++++++++++
 tb/tb_sat_accum_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sat_accum_pipe.sv
// Registered saturating adder/accumulator: mode 0 adds pairs, mode 1 sums ACC_LEN-sample frames.
// Every step clamps to the OUT_WIDTH signed range so the output word never wraps.
module sat_accum_pipe #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int ACC_LEN   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_a,
    input  logic [IN_WIDTH-1:0]  in_b,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 sat_pos,
    output logic                 sat_neg,
    output logic [CNT_WIDTH-1:0] sat_count,
    output logic                 busy
);

    localparam int SW = OUT_WIDTH + 1;
    localparam int LW = $clog2(ACC_LEN + 1);
    localparam logic [OUT_WIDTH-1:0] MAXV = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MINV = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic                 frame_pos_q, frame_pos_d;
    logic                 frame_neg_q, frame_neg_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 sat_pos_q, sat_pos_d;
    logic                 sat_neg_q, sat_neg_d;
    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    logic [SW-1:0]          a_ext, b_ext, acc_ext;
    logic [OUT_WIDTH+1:0]   pair_res, step_res;

    // Packs {pos, neg, data}; the two top sum bits disagree exactly on overflow.
    function automatic logic [OUT_WIDTH+1:0] saturate(input logic [SW-1:0] sum);
        if (sum[SW-1] != sum[SW-2]) begin
            if (sum[SW-1]) saturate = {1'b0, 1'b1, MINV};
            else           saturate = {1'b1, 1'b0, MAXV};
        end else begin
            saturate = {1'b0, 1'b0, sum[OUT_WIDTH-1:0]};
        end
    endfunction

    always_comb begin
        a_ext    = {{(SW-IN_WIDTH){in_a[IN_WIDTH-1]}}, in_a};
        b_ext    = {{(SW-IN_WIDTH){in_b[IN_WIDTH-1]}}, in_b};
        acc_ext  = {acc_q[OUT_WIDTH-1], acc_q};
        pair_res = saturate(a_ext + b_ext);
        step_res = saturate(acc_ext + a_ext);
    end

    // The IDLE/ACCUM state doubles as the latched mode: mode is only looked at from IDLE.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        frame_pos_d = frame_pos_q;
        frame_neg_d = frame_neg_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        sat_pos_d   = sat_pos_q;
        sat_neg_d   = sat_neg_q;
        sat_count_d = sat_count_q;

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (!mode) begin
                        out_valid_d = 1'b1;
                        out_data_d  = pair_res[OUT_WIDTH-1:0];
                        sat_pos_d   = pair_res[OUT_WIDTH+1];
                        sat_neg_d   = pair_res[OUT_WIDTH];
                    end else begin
                        state_d     = ACCUM;
                        acc_d       = a_ext[OUT_WIDTH-1:0];
                        cnt_d       = LW'(1);
                        frame_pos_d = 1'b0;
                        frame_neg_d = 1'b0;
                    end
                end
                ACCUM: begin
                    acc_d       = step_res[OUT_WIDTH-1:0];
                    cnt_d       = cnt_q + LW'(1);
                    frame_pos_d = frame_pos_q | step_res[OUT_WIDTH+1];
                    frame_neg_d = frame_neg_q | step_res[OUT_WIDTH];
                    if (cnt_q == LW'(ACC_LEN - 1)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = step_res[OUT_WIDTH-1:0];
                        sat_pos_d   = frame_pos_d && (step_res[OUT_WIDTH-1:0] == MAXV);
                        sat_neg_d   = frame_neg_d && (step_res[OUT_WIDTH-1:0] == MINV);
                        state_d     = IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Counter tracks the result being registered this edge; clear beats increment.
        if (cnt_clr) begin
            sat_count_d = '0;
        end else if (out_valid_d && (sat_pos_d || sat_neg_d) &&
                     (sat_count_q != {CNT_WIDTH{1'b1}})) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_pos_q <= 1'b0;
            frame_neg_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_pos_q   <= 1'b0;
            sat_neg_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            frame_pos_q <= frame_pos_d;
            frame_neg_q <= frame_neg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_pos_q   <= sat_pos_d;
            sat_neg_q   <= sat_neg_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_pos   = sat_pos_q;
    assign sat_neg   = sat_neg_q;
    assign sat_count = sat_count_q;
    assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_sat_accum_pipe.sv
// Directed bench for sat_accum_pipe: an 8-bit accumulator instance and a 4-bit
// pairwise instance with a 2-bit event counter to reach the counter ceiling.
module tb_sat_accum_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic       aMode = 1'b0, aValid = 1'b0, aClr = 1'b0;
    logic [7:0] aIn = '0, aInB = '0;
    logic       aOutValid, aSatPos, aSatNeg, aBusy;
    logic [7:0] aOutData;
    logic [15:0] aSatCount;

    logic       bMode = 1'b0, bValid = 1'b0, bClr = 1'b0;
    logic [3:0] bIn = '0, bInB = '0;
    logic       bOutValid, bSatPos, bSatNeg, bBusy;
    logic [3:0] bOutData;
    logic [1:0] bSatCount;

    sat_accum_pipe #(.IN_WIDTH(8), .OUT_WIDTH(8), .ACC_LEN(4), .CNT_WIDTH(16)) dutA (
        .clk(clk), .rst(rst), .mode(aMode), .in_valid(aValid), .in_a(aIn), .in_b(aInB),
        .cnt_clr(aClr), .out_valid(aOutValid), .out_data(aOutData), .sat_pos(aSatPos),
        .sat_neg(aSatNeg), .sat_count(aSatCount), .busy(aBusy)
    );

    sat_accum_pipe #(.IN_WIDTH(4), .OUT_WIDTH(4), .ACC_LEN(4), .CNT_WIDTH(2)) dutB (
        .clk(clk), .rst(rst), .mode(bMode), .in_valid(bValid), .in_a(bIn), .in_b(bInB),
        .cnt_clr(bClr), .out_valid(bOutValid), .out_data(bOutData), .sat_pos(bSatPos),
        .sat_neg(bSatNeg), .sat_count(bSatCount), .busy(bBusy)
    );

    // Drive one cycle on instance A, then sit 1 time unit past the edge for sampling.
    task automatic driveA(input logic v, input logic m, input logic [7:0] a, input logic [7:0] b);
        aValid = v; aMode = m; aIn = a; aInB = b;
        @(posedge clk); #1;
        aValid = 1'b0;
    endtask

    task automatic driveB(input logic v, input logic [3:0] a, input logic [3:0] b, input logic clr);
        bValid = v; bMode = 1'b0; bIn = a; bInB = b; bClr = clr;
        @(posedge clk); #1;
        bValid = 1'b0; bClr = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aValid = 1'b1; aMode = 1'b1; aIn = 8'd9;
        @(posedge clk); #1;
        total++; if ({aOutValid, aOutData, aSatPos, aSatNeg, aSatCount, aBusy} !== 28'd0) begin bad++; $display("[TB] FAIL reset_a got=%h exp=0", {aOutValid, aOutData, aSatPos, aSatNeg, aSatCount, aBusy}); end
        total++; if ({bOutValid, bOutData, bSatPos, bSatNeg, bSatCount, bBusy} !== 10'd0) begin bad++; $display("[TB] FAIL reset_b got=%h exp=0", {bOutValid, bOutData, bSatPos, bSatNeg, bSatCount, bBusy}); end
        aValid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_pairwise();
        pulseReset();
        driveB(1'b1, 4'b0111, 4'b0010, 1'b0);
        total++; if ({bOutValid, bOutData, bSatPos, bSatNeg, bSatCount} !== {1'b1, 4'b0111, 1'b1, 1'b0, 2'd1}) begin bad++; $display("[TB] FAIL pair_pos got=%b exp=%b", {bOutValid, bOutData, bSatPos, bSatNeg, bSatCount}, {1'b1, 4'b0111, 1'b1, 1'b0, 2'd1}); end
        driveB(1'b1, 4'b1001, 4'b1001, 1'b0);
        total++; if ({bOutValid, bOutData, bSatPos, bSatNeg, bSatCount} !== {1'b1, 4'b1000, 1'b0, 1'b1, 2'd2}) begin bad++; $display("[TB] FAIL pair_neg got=%b exp=%b", {bOutValid, bOutData, bSatPos, bSatNeg, bSatCount}, {1'b1, 4'b1000, 1'b0, 1'b1, 2'd2}); end
        driveB(1'b1, 4'b1111, 4'b0010, 1'b0);
        total++; if ({bOutValid, bOutData, bSatPos, bSatNeg, bSatCount, bBusy} !== {1'b1, 4'b0001, 1'b0, 1'b0, 2'd2, 1'b0}) begin bad++; $display("[TB] FAIL pair_plain got=%b exp=%b", {bOutValid, bOutData, bSatPos, bSatNeg, bSatCount, bBusy}, {1'b1, 4'b0001, 1'b0, 1'b0, 2'd2, 1'b0}); end
        driveB(1'b0, 4'b0111, 4'b0111, 1'b0);
        total++; if ({bOutValid, bOutData, bSatCount} !== {1'b0, 4'b0001, 2'd2}) begin bad++; $display("[TB] FAIL pair_hold got=%b exp=%b", {bOutValid, bOutData, bSatCount}, {1'b0, 4'b0001, 2'd2}); end
    endtask

    task automatic test_count_sticky();
        logic [1:0] expCnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            driveB(1'b1, 4'b0111, 4'b0111, 1'b0);
            total++; if ({bOutValid, bSatPos, bSatCount} !== {1'b1, 1'b1, expCnt[i]}) begin bad++; $display("[TB] FAIL cnt_step%0d got=%b exp=%b", i, {bOutValid, bSatPos, bSatCount}, {1'b1, 1'b1, expCnt[i]}); end
        end
        driveB(1'b1, 4'b0111, 4'b0111, 1'b1);
        total++; if ({bOutValid, bOutData, bSatPos, bSatCount} !== {1'b1, 4'b0111, 1'b1, 2'd0}) begin bad++; $display("[TB] FAIL cnt_clr_wins got=%b exp=%b", {bOutValid, bOutData, bSatPos, bSatCount}, {1'b1, 4'b0111, 1'b1, 2'd0}); end
        driveB(1'b1, 4'b1000, 4'b1111, 1'b0);
        total++; if ({bOutData, bSatNeg, bSatCount} !== {4'b1000, 1'b1, 2'd1}) begin bad++; $display("[TB] FAIL cnt_after_clr got=%b exp=%b", {bOutData, bSatNeg, bSatCount}, {4'b1000, 1'b1, 2'd1}); end
    endtask

    task automatic test_accum();
        logic [7:0] samples [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            driveA(1'b1, 1'b1, samples[i], 8'd0);
            total++; if ({aOutValid, aBusy} !== 2'b01) begin bad++; $display("[TB] FAIL accum_busy%0d got=%b exp=01", i, {aOutValid, aBusy}); end
            if (i == 1) begin
                driveA(1'b0, 1'b1, 8'd99, 8'd0);
                total++; if ({aOutValid, aBusy} !== 2'b01) begin bad++; $display("[TB] FAIL accum_gap got=%b exp=01", {aOutValid, aBusy}); end
            end
        end
        driveA(1'b1, 1'b1, samples[3], 8'd0);
        total++; if ({aOutValid, aOutData, aSatPos, aSatNeg, aBusy} !== {1'b1, 8'd100, 3'b000}) begin bad++; $display("[TB] FAIL accum_result got=%h exp=%h", {aOutValid, aOutData, aSatPos, aSatNeg, aBusy}, {1'b1, 8'd100, 3'b000}); end
        driveA(1'b0, 1'b1, 8'd0, 8'd0);
        total++; if ({aOutValid, aOutData} !== {1'b0, 8'd100}) begin bad++; $display("[TB] FAIL accum_single got=%h exp=%h", {aOutValid, aOutData}, {1'b0, 8'd100}); end
    endtask

    task automatic test_clamp();
        logic [7:0] s1 [4] = '{8'd100, 8'd100, 8'hCE, 8'hCE};
        pulseReset();
        for (int i = 0; i < 4; i++) driveA(1'b1, 1'b1, s1[i], 8'd0);
        total++; if ({aOutValid, aOutData, aSatPos, aSatNeg, aSatCount} !== {1'b1, 8'd27, 2'b00, 16'd0}) begin bad++; $display("[TB] FAIL clamp_mid got=%h exp=%h", {aOutValid, aOutData, aSatPos, aSatNeg, aSatCount}, {1'b1, 8'd27, 2'b00, 16'd0}); end
        for (int i = 0; i < 4; i++) begin
            driveA(1'b1, 1'b1, 8'd100, 8'd0);
            if (i == 0) begin
                total++; if ({aOutValid, aBusy} !== 2'b01) begin bad++; $display("[TB] FAIL clamp_nobubble got=%b exp=01", {aOutValid, aBusy}); end
            end
        end
        total++; if ({aOutValid, aOutData, aSatPos, aSatNeg, aSatCount} !== {1'b1, 8'h7F, 2'b10, 16'd1}) begin bad++; $display("[TB] FAIL clamp_pos got=%h exp=%h", {aOutValid, aOutData, aSatPos, aSatNeg, aSatCount}, {1'b1, 8'h7F, 2'b10, 16'd1}); end
        for (int i = 0; i < 4; i++) driveA(1'b1, 1'b1, 8'h9C, 8'd0);
        total++; if ({aOutValid, aOutData, aSatPos, aSatNeg, aSatCount} !== {1'b1, 8'h80, 2'b01, 16'd2}) begin bad++; $display("[TB] FAIL clamp_neg got=%h exp=%h", {aOutValid, aOutData, aSatPos, aSatNeg, aSatCount}, {1'b1, 8'h80, 2'b01, 16'd2}); end
    endtask

    task automatic test_reset_midframe();
        pulseReset();
        driveA(1'b1, 1'b1, 8'd50, 8'd0);
        driveA(1'b1, 1'b1, 8'd50, 8'd0);
        pulseReset();
        total++; if ({aOutValid, aBusy, aOutData} !== {2'b00, 8'd0}) begin bad++; $display("[TB] FAIL midrst_state got=%h exp=0", {aOutValid, aBusy, aOutData}); end
        for (int i = 0; i < 3; i++) begin
            driveA(1'b1, 1'b1, 8'd1, 8'd0);
            total++; if (aOutValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_noout%0d got=%b exp=0", i, aOutValid); end
        end
        driveA(1'b1, 1'b1, 8'd1, 8'd0);
        total++; if ({aOutValid, aOutData, aBusy} !== {1'b1, 8'd4, 1'b0}) begin bad++; $display("[TB] FAIL midrst_fresh got=%h exp=%h", {aOutValid, aOutData, aBusy}, {1'b1, 8'd4, 1'b0}); end
    endtask

    task automatic test_mode_toggle();
        pulseReset();
        driveA(1'b1, 1'b1, 8'd5, 8'd100);
        driveA(1'b1, 1'b0, 8'd6, 8'd100);
        driveA(1'b1, 1'b0, 8'd7, 8'd100);
        total++; if ({aOutValid, aBusy} !== 2'b01) begin bad++; $display("[TB] FAIL toggle_ignored got=%b exp=01", {aOutValid, aBusy}); end
        driveA(1'b1, 1'b0, 8'd8, 8'd100);
        total++; if ({aOutValid, aOutData, aBusy} !== {1'b1, 8'd26, 1'b0}) begin bad++; $display("[TB] FAIL toggle_frame got=%h exp=%h", {aOutValid, aOutData, aBusy}, {1'b1, 8'd26, 1'b0}); end
        driveA(1'b1, 1'b0, 8'd3, 8'd4);
        total++; if ({aOutValid, aOutData, aBusy} !== {1'b1, 8'd7, 1'b0}) begin bad++; $display("[TB] FAIL toggle_pair got=%h exp=%h", {aOutValid, aOutData, aBusy}, {1'b1, 8'd7, 1'b0}); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_pairwise();
        test_count_sticky();
        test_accum();
        test_clamp();
        test_reset_midframe();
        test_mode_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
